// File: rtl/and_arb_pkg.sv
// Shared types and sizing helpers for the round-robin AND-unit arbiter.
package and_arb_pkg;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // A single requester still needs a one-bit id field.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/bitwise_and_unit.sv
// Shared combinational AND datapath; zero latency, no flow control.
module bitwise_and_unit
    import and_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o
);

    assign y_o = a_i & b_i;

endmodule

// File: rtl/and_unit_arbiter.sv
// Round-robin arbiter sharing one AND unit: gnt 1 cycle after req, res_valid 1 cycle after gnt, one result per 2 cycles.
// Requests stay pending until granted. Define AND_ARB_ZERO_FLAG_EN to add the res_zero output.
module and_unit_arbiter
    import and_arb_pkg::*;
#(
    parameter  int N_REQ = DEF_N_REQ,
    parameter  int WIDTH = DEF_WIDTH,
    localparam int ID_W  = clog2_min1(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] op_a,
    input  logic [N_REQ*WIDTH-1:0] op_b,
    output logic [N_REQ-1:0]       gnt,
    output logic [WIDTH-1:0]       res,
    output logic                   res_valid,
    output logic [ID_W-1:0]        res_id,
    output logic                   busy
`ifdef AND_ARB_ZERO_FLAG_EN
    ,
    output logic                   res_zero
`endif
);

    arb_state_t       state_q, state_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [ID_W-1:0]  res_id_q, res_id_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             res_valid_q, res_valid_d;

    logic [WIDTH-1:0] and_y;
    logic             win_vld;
    logic             hi_vld;
    logic [ID_W-1:0]  hi_idx, lo_idx, win_idx;
    logic [WIDTH-1:0] a_sel, b_sel;

    bitwise_and_unit #(
        .WIDTH (WIDTH)
    ) u_and (
        .a_i (a_q),
        .b_i (b_q),
        .y_o (and_y)
    );

    // Requesters above the last winner take priority; otherwise wrap to the lowest.
    always_comb begin
        hi_vld = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                if (i > int'(rr_ptr_q)) begin
                    hi_vld = 1'b1;
                    hi_idx = ID_W'(i);
                end else begin
                    lo_idx = ID_W'(i);
                end
            end
        end
    end

    assign win_vld = |req;
    assign win_idx = hi_vld ? hi_idx : lo_idx;

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_idx == ID_W'(i)) begin
                a_sel = op_a[i*WIDTH +: WIDTH];
                b_sel = op_b[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        res_id_d    = res_id_q;
        gnt_d       = '0;
        res_valid_d = 1'b0;
        case (state_q)
            IDLE, RESP: begin
                if (win_vld) begin
                    a_d      = a_sel;
                    b_d      = b_sel;
                    id_d     = win_idx;
                    rr_ptr_d = win_idx;
                    gnt_d    = N_REQ'(1) << win_idx;
                    state_d  = CALC;
                end else begin
                    state_d  = IDLE;
                end
            end
            CALC: begin
                res_d       = and_y;
                res_id_d    = id_q;
                res_valid_d = 1'b1;
                state_d     = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= ID_W'(N_REQ - 1);
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            res_id_q    <= '0;
            gnt_q       <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            res_id_q    <= res_id_d;
            gnt_q       <= gnt_d;
            res_valid_q <= res_valid_d;
        end
    end

`ifdef AND_ARB_ZERO_FLAG_EN
    logic res_zero_q, res_zero_d;

    always_comb begin
        res_zero_d = res_zero_q;
        if (state_q == CALC) begin
            res_zero_d = ~|and_y;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_zero_q <= 1'b0;
        end else begin
            res_zero_q <= res_zero_d;
        end
    end

    assign res_zero = res_zero_q;
`endif

    assign gnt       = gnt_q;
    assign res       = res_q;
    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign busy      = (state_q == CALC);

endmodule

// File: tb/tb_and_unit_arbiter.sv
// Self-checking bench for and_unit_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_and_unit_arbiter;

    localparam int N = 4;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] op_a;
    logic [N*W-1:0] op_b;
    logic [N-1:0]   gnt;
    logic [W-1:0]   res;
    logic           res_valid;
    logic [1:0]     res_id;
    logic           busy;
`ifdef AND_ARB_ZERO_FLAG_EN
    logic           res_zero;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: an arbitration slot is free unless a grant was issued at the previous edge.
    bit         m_calc;
    int         m_last;
    int         m_w;
    logic [3:0] m_a, m_b;
    logic [3:0] e_gnt, e_res;
    logic       e_valid, e_busy, e_zero;
    logic [1:0] e_id;

    always #5 clk = ~clk;

    and_unit_arbiter #(
        .N_REQ (N),
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .op_a      (op_a),
        .op_b      (op_b),
        .gnt       (gnt),
        .res       (res),
        .res_valid (res_valid),
        .res_id    (res_id),
        .busy      (busy)
`ifdef AND_ARB_ZERO_FLAG_EN
        ,
        .res_zero  (res_zero)
`endif
    );

    task automatic model_reset();
        m_calc  = 0;
        m_last  = N - 1;
        m_w     = 0;
        m_a     = '0;
        m_b     = '0;
        e_gnt   = '0;
        e_res   = '0;
        e_valid = 1'b0;
        e_busy  = 1'b0;
        e_zero  = 1'b0;
        e_id    = '0;
    endtask

    task automatic model_update();
        e_valid = 1'b0;
        e_gnt   = '0;
        if (m_calc) begin
            e_res   = m_a & m_b;
            e_id    = 2'(m_w);
            e_zero  = (e_res == 4'h0);
            e_valid = 1'b1;
            m_calc  = 0;
        end else if (req != '0) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (req[c]) begin
                    m_w = c;
                    break;
                end
            end
            m_a    = op_a[m_w*W +: W];
            m_b    = op_b[m_w*W +: W];
            m_last = m_w;
            e_gnt  = 4'(1 << m_w);
            m_calc = 1;
        end
        e_busy = m_calc;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_update();
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req   = '0;
        op_a  = '0;
        op_b  = '0;
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({gnt, res, res_valid, res_id, busy} !== 12'h000) begin
            errors++;
            $display("FAIL reset_values: got %h required 000", {gnt, res, res_valid, res_id, busy});
        end
        op_a = 16'h00E0;
        op_b = 16'h0070;
        req  = 4'b0010;
        tick();
        req = '0;
        tick();
        checks++;
        if ({res_valid, res, res_id} !== {1'b1, 4'h6, 2'd1}) begin
            errors++;
            $display("FAIL reset_pre_result: got v=%b res=%h id=%0d required v=1 res=6 id=1", res_valid, res, res_id);
        end
        op_a[11:8] = 4'hF;
        op_b[11:8] = 4'hF;
        req = 4'b0100;
        tick();
        checks++;
        if ({gnt, busy} !== {4'b0100, 1'b1}) begin
            errors++;
            $display("FAIL reset_pre_grant: got gnt=%b busy=%b required gnt=0100 busy=1", gnt, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt, res, res_valid, res_id, busy} !== 12'h000) begin
            errors++;
            $display("FAIL reset_async: got %h required 000", {gnt, res, res_valid, res_id, busy});
        end
        req = '0;
        tick();
        tick();
        rst_n = 1'b1;
        req   = 4'b1111;
        tick();
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL reset_first_grant: got %b required 0001", gnt);
        end
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_single();
        apply_reset();
        op_a = 16'h000B;
        op_b = 16'h0006;
        req  = 4'b0001;
        tick();
        checks++;
        if ({gnt, res_valid, busy} !== {4'b0001, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL single_grant: got gnt=%b v=%b busy=%b required 0001 0 1", gnt, res_valid, busy);
        end
        req = '0;
        tick();
        checks++;
        if ({gnt, res_valid, res, res_id} !== {4'b0000, 1'b1, 4'b0010, 2'd0}) begin
            errors++;
            $display("FAIL single_result: got gnt=%b v=%b res=%b id=%0d required 0000 1 0010 0", gnt, res_valid, res, res_id);
        end
        tick();
        checks++;
        if ({res_valid, res, busy} !== {1'b0, 4'b0010, 1'b0}) begin
            errors++;
            $display("FAIL single_hold: got v=%b res=%b busy=%b required 0 0010 0", res_valid, res, busy);
        end
    endtask

    task automatic test_all_four();
        logic [3:0] exp_r;
        apply_reset();
        op_a = 16'hA5F3;
        op_b = 16'h6C9E;
        req  = 4'b1111;
        for (int k = 0; k < N; k++) begin
            tick();
            checks++;
            if (gnt !== 4'(1 << k)) begin
                errors++;
                $display("FAIL all4_grant%0d: got %b required %b", k, gnt, 4'(1 << k));
            end
            req[k] = 1'b0;
            tick();
            exp_r = op_a[k*W +: W] & op_b[k*W +: W];
            checks++;
            if ({res_valid, res_id, res} !== {1'b1, 2'(k), exp_r}) begin
                errors++;
                $display("FAIL all4_result%0d: got v=%b id=%0d res=%h required v=1 id=%0d res=%h", k, res_valid, res_id, res, k, exp_r);
            end
        end
        tick();
        checks++;
        if ({gnt, busy, res_valid} !== 6'b0) begin
            errors++;
            $display("FAIL all4_idle: got gnt=%b busy=%b v=%b required all 0", gnt, busy, res_valid);
        end
    endtask

    task automatic test_fairness();
        apply_reset();
        op_a = 16'h0C0F;
        op_b = 16'h0A03;
        req  = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (gnt !== ((k % 2 == 1) ? 4'b0100 : 4'b0001)) begin
                errors++;
                $display("FAIL fair_grant%0d: got %b required %b", k, gnt, (k % 2 == 1) ? 4'b0100 : 4'b0001);
            end
            if (k == 3) req = '0;
            tick();
            checks++;
            if ({res_valid, res} !== {1'b1, (k % 2 == 1) ? 4'b1000 : 4'b0011}) begin
                errors++;
                $display("FAIL fair_result%0d: got v=%b res=%b required v=1 res=%b", k, res_valid, res, (k % 2 == 1) ? 4'b1000 : 4'b0011);
            end
        end
        tick();
        checks++;
        if ({gnt, busy} !== 5'b0) begin
            errors++;
            $display("FAIL fair_drain: got gnt=%b busy=%b required 0000 0", gnt, busy);
        end
    endtask

    task automatic test_reset_calc();
        apply_reset();
        op_a = 16'h7D3E;
        op_b = 16'hB6E5;
        req  = 4'b1000;
        tick();
        checks++;
        if ({gnt, busy} !== {4'b1000, 1'b1}) begin
            errors++;
            $display("FAIL rcalc_grant: got gnt=%b busy=%b required 1000 1", gnt, busy);
        end
        rst_n = 1'b0;
        req   = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({res_valid, gnt} !== 5'b0) begin
                errors++;
                $display("FAIL rcalc_held%0d: got v=%b gnt=%b required 0 0000", k, res_valid, gnt);
            end
        end
        rst_n = 1'b1;
        req   = 4'b1111;
        tick();
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL rcalc_first_grant: got %b required 0001", gnt);
        end
        req = '0;
        tick();
        checks++;
        if ({res_valid, res_id, res} !== {1'b1, 2'd0, 4'hE & 4'h5}) begin
            errors++;
            $display("FAIL rcalc_result: got v=%b id=%0d res=%h required 1 0 4", res_valid, res_id, res);
        end
        tick();
    endtask

`ifdef AND_ARB_ZERO_FLAG_EN
    task automatic test_zero_flag();
        apply_reset();
        op_a = 16'h000A;
        op_b = 16'h0005;
        req  = 4'b0001;
        tick();
        req = '0;
        tick();
        checks++;
        if ({res_valid, res, res_zero} !== {1'b1, 4'b0000, 1'b1}) begin
            errors++;
            $display("FAIL zero_set: got v=%b res=%b z=%b required 1 0000 1", res_valid, res, res_zero);
        end
        op_a = 16'h000E;
        op_b = 16'h0007;
        req  = 4'b0001;
        tick();
        req = '0;
        tick();
        checks++;
        if ({res_valid, res, res_zero} !== {1'b1, 4'b0110, 1'b0}) begin
            errors++;
            $display("FAIL zero_clear: got v=%b res=%b z=%b required 1 0110 0", res_valid, res, res_zero);
        end
    endtask
`endif

    task automatic test_random();
        bit [N-1:0] pend;
        int         waits [N];
        apply_reset();
        pend = '0;
        for (int i = 0; i < N; i++) waits[i] = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            tick();
            checks++;
            if (gnt !== e_gnt) begin
                errors++;
                $display("FAIL rand_gnt c%0d: got %b required %b", cyc, gnt, e_gnt);
            end
            checks++;
            if ({res_valid, busy} !== {e_valid, e_busy}) begin
                errors++;
                $display("FAIL rand_flags c%0d: got v=%b busy=%b required v=%b busy=%b", cyc, res_valid, busy, e_valid, e_busy);
            end
            checks++;
            if ({res, res_id} !== {e_res, e_id}) begin
                errors++;
                $display("FAIL rand_res c%0d: got res=%h id=%0d required res=%h id=%0d", cyc, res, res_id, e_res, e_id);
            end
`ifdef AND_ARB_ZERO_FLAG_EN
            checks++;
            if (res_zero !== e_zero) begin
                errors++;
                $display("FAIL rand_zero c%0d: got %b required %b", cyc, res_zero, e_zero);
            end
`endif
            if (gnt != '0) begin
                for (int i = 0; i < N; i++) begin
                    if (gnt[i]) begin
                        waits[i] = 0;
                    end else if (req[i]) begin
                        waits[i]++;
                        checks++;
                        if (waits[i] > N - 1) begin
                            errors++;
                            $display("FAIL rand_starve c%0d: requester %0d waited %0d grants, allowed %0d", cyc, i, waits[i], N - 1);
                        end
                    end
                end
            end
            for (int i = 0; i < N; i++) begin
                if (e_gnt[i])                                  pend[i] = 1'b0;
                else if (!pend[i] && $urandom_range(0, 2) == 0) pend[i] = 1'b1;
            end
            req  = pend;
            op_a = 16'($urandom);
            op_b = 16'($urandom);
        end
        req = '0;
        tick();
        tick();
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        op_a  = '0;
        op_b  = '0;
        test_reset();
        test_single();
        test_all_four();
        test_fairness();
        test_reset_calc();
`ifdef AND_ARB_ZERO_FLAG_EN
        test_zero_flag();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/and_unit_arbiter.md
Name: and_unit_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one registered bitwise-AND datapath among N_REQ requesters (game logic, input decoders, LED pattern masks).
- Each requester presents two operand words with a request. The block grants one requester, captures its operands, computes the AND, and returns a tagged result pulse.
- Sits between requester modules and the single AND unit instance.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..8.
- WIDTH, 4, operand/result width in bits; legal range 1..32.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  N_REQ  request vector; bit i from requester i.
- op_a  in  N_REQ*WIDTH  packed operand A; requester i at [i*WIDTH +: WIDTH].
- op_b  in  N_REQ*WIDTH  packed operand B; same packing.
- gnt  out  N_REQ  registered one-hot grant, one-cycle pulse.
- res  out  WIDTH  registered AND result; holds until the next result.
- res_valid  out  1  one-cycle pulse when res/res_id are new.
- res_id  out  ID_W  index of the requester owning res; ID_W = max(1, clog2(N_REQ)).
- busy  out  1  high in CALC state.

Behaviour:
- Reset (asynchronous, rst_n=0) drives:
  - gnt=0, res=0, res_valid=0, res_id=0, busy=0.
  - state=IDLE.
  - rr_ptr=N_REQ-1, so requester 0 has top priority first.
  - Operand registers = 0.
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - req==0: stay in IDLE.
  - Otherwise pick winner w = first set bit scanning from (rr_ptr+1) mod N_REQ upward with wrap.
  - At the clock edge: capture op_a/op_b slices of w into a_q/b_q, set id_q=w, rr_ptr=w, gnt=onehot(w), go to CALC.
- CALC (one cycle):
  - gnt is high this cycle only; busy=1.
  - At the edge: res=a_q & b_q via the sub-module, res_id=id_q, res_valid=1, gnt=0, go to RESP.
- RESP (one cycle):
  - res_valid high this cycle only.
  - Arbitration runs exactly as in IDLE. If any req, grant, capture and go to CALC; else go to IDLE.
- Latency and throughput:
  - req sampled at edge T → gnt high in cycle T+1 → res_valid high in cycle T+2.
  - Maximum throughput: one result per 2 cycles.
- Handshake rule:
  - req is sampled only in IDLE and RESP.
  - The requester must deassert req in the cycle after it sees gnt; req still high in RESP counts as a new request.
  - Operands only need to be stable in the cycle req is sampled.
- Simultaneous requests: exactly one grant per arbitration. Losers stay pending with no loss; starvation-free, worst-case wait N_REQ-1 grants.
- rr_ptr wraps from N_REQ-1 to 0.
- Reset mid-operation (CALC or RESP): the in-flight operation is dropped, no res_valid is produced, and the next grant starts from requester 0.
- Outputs change only on clk edges or on asynchronous reset.

Optional Feature:
- Macro: AND_ARB_ZERO_FLAG_EN.
- Defined:
  - Adds output res_zero, 1 bit.
  - res_zero is registered with res: 1 when a_q & b_q == 0.
  - Reset value 0; holds with res.
- Undefined: no res_zero port or logic; the rest of the behaviour is identical.

Decomposition:
- Package and_arb_pkg holds:
  - state enum type (IDLE, CALC, RESP);
  - function clog2_min1 used for ID_W;
  - constant default widths.
- One sub-module, bitwise_and_unit (parameter WIDTH): purely combinational a & b, instantiated once. The arbiter owns all registers.

Test Plan:
- Reset: assert rst_n=0 mid-simulation → all outputs 0 immediately, without waiting for clk; first grant after release goes to requester 0.
- Single request: req=0001, op_a[3:0]=1011, op_b[3:0]=0110 → gnt=0001 one cycle later; next cycle res_valid=1, res=0010, res_id=0.
- All four requesting together, each dropping req after its gnt → grants 0001, 0010, 0100, 1000 on alternate cycles; four res_valid pulses two cycles apart with matching res_id 0..3.
- Fairness: requesters 0 and 2 re-assert continuously (ops 1111/0011 and 1100/1010) → grant order 0,2,0,2; results 0011, 1000 alternating.
- Reset during CALC (rst_n low for 3 cycles) → no res_valid at any point; after release req=1111 grants requester 0 first.
- With AND_ARB_ZERO_FLAG_EN defined: op_a=1010, op_b=0101 → res=0000, res_zero=1; next op 1110&0111 → res=0110, res_zero=0.
